// File: rtl/filt_mac_mc_if.sv
// Sample/coefficient/result bundle for filt_mac_mc. The slave modport is the filter;
// the master modport is the channelised source that also consumes the results.
interface filt_mac_mc_if #(
  parameter int gp_inp_width    = 8,
  parameter int gp_coeff_width  = 12,
  parameter int gp_coeff_length = 17,
  parameter int gp_nch          = 2,
  parameter int gp_oup_width    = gp_inp_width + gp_coeff_width + $clog2(gp_coeff_length)
);
  localparam int CW = (gp_nch > 1) ? $clog2(gp_nch) : 1;
  localparam int AW = $clog2(gp_coeff_length);

  logic                             i_ena;
  logic                             i_valid;
  logic [CW-1:0]                    i_ch;
  logic signed [gp_inp_width-1:0]   i_data;
  logic                             o_ready;
  logic                             i_coeff_we;
  logic [AW-1:0]                    i_coeff_addr;
  logic signed [gp_coeff_width-1:0] i_coeff_data;
  logic                             o_valid;
  logic [CW-1:0]                    o_ch;
  logic signed [gp_oup_width-1:0]   o_data;

  modport master (
    output i_ena, i_valid, i_ch, i_data, i_coeff_we, i_coeff_addr, i_coeff_data,
    input  o_ready, o_valid, o_ch, o_data
  );

  modport slave (
    input  i_ena, i_valid, i_ch, i_data, i_coeff_we, i_coeff_addr, i_coeff_data,
    output o_ready, o_valid, o_ch, o_data
  );
endinterface

// File: rtl/filt_mac_mc.sv
// Time-multiplexed multi-channel FIR: one multiplier, one delay line per channel, shared coefficients.
// Result pulses N+1 edges after accept; o_ready low while busy; results have no back-pressure.
module filt_mac_mc #(
  parameter int gp_inp_width    = 8,
  parameter int gp_coeff_width  = 12,
  parameter int gp_coeff_length = 17,
  parameter int gp_nch          = 2,
  parameter int gp_symm         = 1,
  parameter int gp_oup_width    = gp_inp_width + gp_coeff_width + $clog2(gp_coeff_length)
) (
  input logic           i_clk,
  input logic           i_rst_an,
  filt_mac_mc_if.slave  bus
);
  localparam int L  = gp_coeff_length;
  localparam int N  = (gp_symm != 0) ? (L + 1) / 2 : L;
  localparam int CW = (gp_nch > 1) ? $clog2(gp_nch) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = gp_inp_width + 1;
  localparam int MW = PW + gp_coeff_width;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic signed [gp_inp_width-1:0]   line_q [gp_nch][L];
  logic signed [gp_inp_width-1:0]   line_d [gp_nch][L];
  logic signed [gp_coeff_width-1:0] coeff_q [N];
  logic signed [gp_coeff_width-1:0] coeff_d [N];
  logic [KW-1:0]                    k_q, k_d;
  logic [CW-1:0]                    ch_q, ch_d;
  logic signed [gp_oup_width-1:0]   acc_q, acc_d;
  logic                             valid_q, valid_d;
  logic [CW-1:0]                    och_q, och_d;
  logic signed [gp_oup_width-1:0]   data_q, data_d;

  logic signed [gp_inp_width-1:0]   x_lo, x_hi;
  logic signed [PW-1:0]             pre;
  logic signed [MW-1:0]             prod;
  int                               kk, chi, ich, cai;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    och_d   = och_q;
    data_d  = data_q;
    line_d  = line_q;
    coeff_d = coeff_q;

    kk   = int'(k_q);
    chi  = int'(ch_q);
    ich  = int'(bus.i_ch);
    cai  = int'(bus.i_coeff_addr);
    x_lo = line_q[chi][kk];
    x_hi = line_q[chi][L-1-kk];
    // Odd-length symmetric filters have an unpaired centre tap.
    if (gp_symm != 0 && !((L % 2 == 1) && (kk == (L - 1) / 2)))
      pre = PW'(x_lo) + PW'(x_hi);
    else
      pre = PW'(x_lo);
    prod = MW'(pre) * MW'(coeff_q[kk]);

    if (bus.i_ena) begin
      valid_d = 1'b0;
      if (state_q == S_IDLE && bus.i_coeff_we && cai < N)
        coeff_d[cai] = bus.i_coeff_data;
      case (state_q)
        S_IDLE: begin
          if (bus.i_valid && ich < gp_nch) begin
            for (int t = L - 1; t > 0; t--)
              line_d[ich][t] = line_q[ich][t-1];
            line_d[ich][0] = bus.i_data;
            ch_d    = bus.i_ch;
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MAC;
          end
        end
        S_MAC: begin
          acc_d = acc_q + gp_oup_width'(prod);
          if (kk == N - 1)
            state_d = S_DONE;
          else
            k_d = k_q + 1'b1;
        end
        S_DONE: begin
          valid_d = 1'b1;
          data_d  = acc_q;
          och_d   = ch_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      och_q   <= '0;
      data_q  <= '0;
      for (int c = 0; c < gp_nch; c++)
        for (int t = 0; t < L; t++)
          line_q[c][t] <= '0;
      for (int t = 0; t < N; t++)
        coeff_q[t] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      och_q   <= och_d;
      data_q  <= data_d;
      line_q  <= line_d;
      coeff_q <= coeff_d;
    end
  end

  assign bus.o_ready = (state_q == S_IDLE);
  assign bus.o_valid = valid_q;
  assign bus.o_ch    = och_q;
  assign bus.o_data  = data_q;
endmodule
